flunky_apb_master: RTL and testbench
====================================

// Module: flunky_apb_master
// PURPOSE
//  Bridge from a PicoRV32 native memory port to an APB3 initiator: the core is the requester, APB is
//  the completer side. Forwards in-window core requests as one APB transfer each; returns read data
//  and completion to the core. Adds pslverr/timeout capture and a sticky error for firmware.
// PARAMETERS
//  ADDR_W    16            APB paddr width; paddr = mem_addr[ADDR_W-1:0] with [1:0] forced 0
//  WIN_BASE  32'h0300_0000 window base; request accepted when (mem_addr & WIN_MASK) == WIN_BASE
//  WIN_MASK  32'hFFFF_0000 window compare mask
//  TIMEOUT   255           max ACCESS cycles awaiting pready; 0 = never time out
//  ERR_DATA  32'hDEAD_BEEF mem_rdata returned on an error or timed-out read
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  resetn     in   1       asynchronous, active-low reset
//  mem_valid  in   1       core request valid
//  mem_addr   in   32      core byte address
//  mem_wdata  in   32      core write data
//  mem_wstrb  in   4       byte strobes; 0 = read
//  mem_ready  out  1       one-cycle completion pulse to core
//  mem_rdata  out  32      read data; holds until the next read completes
//  paddr      out  ADDR_W  APB address
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction, 1 = write
//  pwdata     out  32      APB write data
//  pstrb      out  4       APB write strobes (0 on reads)
//  prdata     in   32      APB read data
//  pready     in   1       APB ready
//  pslverr    in   1       APB slave error
//  err_clr    in   1       clears err_flag/err_addr
//  err_flag   out  1       sticky: pslverr seen or timeout occurred
//  err_addr   out  32      mem_addr of the first failing transfer since the last clear
//  busy       out  1       high in any state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0; takes effect immediately (mid-transfer too),
//    so psel/penable drop asynchronously.
//  - FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//  - IDLE: on mem_valid & in-window & !mem_ready, register addr/wdata/wstrb/pwrite(=|mem_wstrb);
//    go to SETUP. Out-of-window requests are ignored; mem_ready is never driven for them.
//  - SETUP (1 cycle): psel=1, penable=0; go to ACCESS.
//  - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb stable from SETUP through ACCESS.
//    On pready: latch prdata into mem_rdata (reads only; ERR_DATA if pslverr); go to DONE.
//  - Timeout: counter counts ACCESS cycles with pready=0. Reaching TIMEOUT ends the transfer
//    (psel/penable low next cycle), returns ERR_DATA on reads, sets err_flag, goes to DONE.
//  - DONE: psel=penable=0, mem_ready=1 for exactly this cycle; go to IDLE.
//    The core drops mem_valid after this cycle, so no double issue occurs.
//  - Zero-wait latency: request seen in cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> mem_ready cycle 3.
//    Each wait state adds 1 cycle.
//  - Errors: pslverr with pready, or a timeout, sets err_flag. err_addr is loaded only when err_flag
//    was 0. Writes still complete to the core.
//  - err_clr has priority over a simultaneous new error in the same cycle. The new error is lost, by design.
//  - mem_wstrb 4'b0000 -> read, pstrb 0. Partial strobes pass through unchanged.
//  - If mem_valid deasserts mid-transfer (illegal), the APB transfer still completes and the DONE pulse
//    still occurs.
// TESTING
//  - Read 0x0300_0010, pready=1 at ACCESS, prdata=0x1234_5678 -> paddr=0x0010, mem_ready in cycle 3,
//    mem_rdata=0x1234_5678.
//  - Write 0x0300_0024, wdata=0xA5A5_0001, wstrb=0x3, pready low 2 cycles -> pwrite=1, pstrb=0x3,
//    signals stable 4 cycles, mem_ready in cycle 5.
//  - Read 0x0400_0000 (out of window) -> psel never asserted, mem_ready stays 0 for 20 cycles.
//  - Read with pslverr=1 at 0x0300_0100 -> mem_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0x0300_0100.
//    A second error leaves err_addr unchanged; err_clr -> both 0.
//  - TIMEOUT=4, pready held 0 -> psel drops after 4 ACCESS cycles, mem_ready pulses, err_flag=1.
//    The next normal read succeeds.
//  - resetn low during ACCESS -> psel/penable/busy 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/flunky_apb_master.sv
// flunky_apb_master
//   Bridges a PicoRV32 native memory port onto an APB3 initiator. Each
//   in-window core request becomes exactly one APB transfer. Read data and a
//   one-cycle completion pulse go back to the core. An APB slave error or an
//   ACCESS-phase timeout sets a sticky error flag and records the core address
//   of the first failing transfer since the last clear.
//
//   Ports
//     clk, resetn          clock (rising edge), asynchronous active-low reset
//     mem_valid/addr/      core request: valid, byte address, write data,
//     wdata/wstrb          byte strobes (0 = read)
//     mem_ready/rdata      completion pulse, read data (held until next read)
//     paddr..pstrb         APB request outputs
//     prdata/pready/pslverr APB response inputs
//     err_clr              clears err_flag/err_addr (wins over a new error)
//     err_flag/err_addr    sticky error, address of first failing transfer
//     busy                 high whenever the bridge is not idle
module flunky_apb_master #(
   parameter int unsigned ADDR_W   = 16,
   parameter logic [31:0] WIN_BASE = 32'h0300_0000,
   parameter logic [31:0] WIN_MASK = 32'hFFFF_0000,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_valid,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [31:0]       pwdata,
   output logic [3:0]        pstrb,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr,
   input  logic              err_clr,
   output logic              err_flag,
   output logic [31:0]       err_addr,
   output logic              busy
);

   // Counter only needs to reach TIMEOUT-1; the terminal ACCESS cycle is
   // detected combinationally against that value.
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;

   logic w_in_win;
   logic w_start;
   logic w_timeout;
   logic w_fail;

   assign w_in_win  = ((mem_addr & WIN_MASK) == WIN_BASE);
   // mem_ready guards against re-issuing the request the core is still
   // holding during the completion cycle.
   assign w_start   = mem_valid & w_in_win & ~mem_ready;
   assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !pready
                      && (r_cnt == TO_LAST);
   assign w_fail    = (r_state == S_ACCESS) && ((pready && pslverr) || w_timeout);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         paddr     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         err_flag  <= 1'b0;
         err_addr  <= '0;
         busy      <= 1'b0;
      end else begin
         mem_ready <= 1'b0;

         // A clear in the same cycle as a new failure drops that failure.
         if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
         end else if (w_fail && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= r_addr;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_addr  <= mem_addr;
                  paddr   <= {mem_addr[ADDR_W-1:2], 2'b00};
                  pwdata  <= mem_wdata;
                  pstrb   <= mem_wstrb;
                  pwrite  <= |mem_wstrb;
                  psel    <= 1'b1;
                  busy    <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               penable <= 1'b1;
               r_cnt   <= '0;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready) begin
                  if (!pwrite) mem_rdata <= pslverr ? ERR_DATA : prdata;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  mem_ready <= 1'b1;
                  r_state   <= S_DONE;
               end else if (w_timeout) begin
                  if (!pwrite) mem_rdata <= ERR_DATA;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  mem_ready <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flunky_apb_master.sv
// tb_flunky_apb_master
//   Directed and randomized transfers against flunky_apb_master (TIMEOUT=4).
//   The bench plays both the core and an APB completer; expectations come
//   from a transaction-level model (latency formula, rdata/error registers).
module tb_flunky_apb_master;

   localparam int unsigned TO   = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [15:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic        err_clr = 1'b0;
   logic        err_flag;
   logic [31:0] err_addr;
   logic        busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model of the core-visible registers
   logic [31:0] m_rdata = '0;
   logic        m_flag  = 1'b0;
   logic [31:0] m_eaddr = '0;

   flunky_apb_master #(.TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .err_clr(err_clr), .err_flag(err_flag),
      .err_addr(err_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One core request, APB completer inserting `waits` wait states.
   // waits >= TO means the completer never answers (timeout path).
   // clr_same raises err_clr in the cycle the response is sampled.
   // rst_at != 0 asserts resetn in that ACCESS cycle and abandons the transfer.
   task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int unsigned waits, input logic err, input logic [31:0] rd,
                       input logic clr_same, input int unsigned rst_at);
      int unsigned cyc = 0;
      int unsigned acc = 0;
      int unsigned exp_lat;
      logic        is_to;
      logic        done = 1'b0;
      logic        clr_pend = 1'b0;
      logic [15:0] exp_paddr;
      is_to     = (waits >= TO);
      exp_lat   = is_to ? (2 + TO) : (3 + waits);
      exp_paddr = {a[15:2], 2'b00};
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (clr_pend) begin
            err_clr  = 1'b0;
            clr_pend = 1'b0;
         end
         pready  = 1'b0;
         pslverr = 1'($urandom_range(0, 1));
         prdata  = ~rd;
         if (mem_ready) begin
            done = 1'b1;
            check("latency", 64'(cyc), 64'(exp_lat));
            check("done_bus", {psel, penable, busy}, 3'b001);
            if (ws == 4'h0) m_rdata = (is_to || err) ? ERRD : rd;
            if (clr_same) begin
               m_flag  = 1'b0;
               m_eaddr = '0;
            end else if ((is_to || err) && !m_flag) begin
               m_flag  = 1'b1;
               m_eaddr = a;
            end
            check("mem_rdata", mem_rdata, m_rdata);
            check("err_flag", err_flag, m_flag);
            check("err_addr", err_addr, m_eaddr);
            mem_valid = 1'b0;
         end else if (psel) begin
            check("busy", busy, 1'b1);
            check("ctl_stable", {paddr, pstrb, pwrite}, {exp_paddr, ws, |ws});
            check("pwdata_stable", pwdata, wd);
            if (!penable) begin
               check("setup_cycle", 64'(cyc), 64'd1);
            end else begin
               acc++;
               if (rst_at != 0 && acc == rst_at) begin
                  resetn = 1'b0;
                  #1;
                  check("rst_async", {psel, penable, busy, mem_ready}, 4'b0000);
                  check("rst_err", {err_flag, err_addr}, 33'd0);
                  check("rst_rdata", mem_rdata, 32'd0);
                  m_rdata   = '0;
                  m_flag    = 1'b0;
                  m_eaddr   = '0;
                  mem_valid = 1'b0;
                  repeat (2) @(negedge clk);
                  resetn = 1'b1;
                  return;
               end
               if (!is_to && acc == waits + 1) begin
                  pready  = 1'b1;
                  pslverr = err;
                  prdata  = rd;
                  if (clr_same) begin
                     err_clr  = 1'b1;
                     clr_pend = 1'b1;
                  end
               end
            end
         end
      end
      check("completed", done, 1'b1);
      mem_valid = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      pready  = 1'b0;
      check("post_idle", {psel, penable, mem_ready, busy}, 4'b0000);
   endtask

   task automatic idle_req(input logic [31:0] a, input int unsigned ncyc);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = 4'($urandom_range(0, 15));
      for (int unsigned i = 0; i < ncyc; i++) begin
         @(negedge clk);
         check("oow_quiet", {psel, mem_ready, busy}, 3'b000);
      end
      mem_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_flag  = 1'b0;
      m_eaddr = '0;
      check("clr_flag", err_flag, m_flag);
      check("clr_addr", err_addr, m_eaddr);
   endtask

   initial begin
      logic [31:0] ra;
      logic [3:0]  rs;
      int unsigned rw;

      repeat (3) @(negedge clk);
      check("reset_ctl", {psel, penable, pwrite, mem_ready, busy, err_flag}, 6'd0);
      check("reset_paddr", paddr, 16'd0);
      check("reset_data", {pwdata, pstrb}, 36'd0);
      check("reset_rdata", mem_rdata, 32'd0);
      check("reset_eaddr", err_addr, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // zero-wait read
      xfer(32'h0300_0010, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 0);
      // write with two wait states, partial strobes
      xfer(32'h0300_0024, 32'hA5A5_0001, 4'h3, 2, 1'b0, 32'h0, 1'b0, 0);
      // out of window
      idle_req(32'h0400_0000, 20);
      // slave error, second error keeps first address, then clear
      xfer(32'h0300_0100, 32'h0, 4'h0, 1, 1'b1, 32'h5555_AAAA, 1'b0, 0);
      xfer(32'h0300_0200, 32'h0, 4'h0, 0, 1'b1, 32'h0BAD_0BAD, 1'b0, 0);
      pulse_clr();
      // timeout then a normal read
      xfer(32'h0300_0300, 32'h0, 4'h0, 10, 1'b0, 32'h0, 1'b0, 0);
      xfer(32'h0300_0304, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
      pulse_clr();
      // write error with clear in the same cycle: error lost
      xfer(32'h0300_0400, 32'h1111_2222, 4'hF, 1, 1'b1, 32'h0, 1'b1, 0);
      // reset during ACCESS, then a normal read
      xfer(32'h0300_0500, 32'h0, 4'h0, 10, 1'b0, 32'h0, 1'b0, 2);
      xfer(32'h0300_0504, 32'h0, 4'h0, 1, 1'b0, 32'h7777_8888, 1'b0, 0);

      // randomized traffic
      for (int unsigned n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            idle_req({16'h0400 + 16'($urandom_range(0, 255)), 16'($urandom)}, 5);
         end else if ($urandom_range(0, 14) == 0) begin
            pulse_clr();
         end else begin
            ra = {16'h0300, 16'($urandom)};
            rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rw = $urandom_range(0, 6);
            xfer(ra, $urandom, rs, rw, ($urandom_range(0, 4) == 0), $urandom,
                 (rw < TO) && ($urandom_range(0, 9) == 0), 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
